// File: rtl/m68k_bus_ctrl_if.sv
// m68k_bus_ctrl_if: 68030 bus strobes from the CPU and the decoded selects/acks back.
interface m68k_bus_ctrl_if;
    logic [31:0] ADR_OUT;
    logic        ASn;
    logic        DSn;
    logic        RWn;
    logic [1:0]  SIZE;
    logic        IO_RDYn;
    logic [1:0]  DSACKn;
    logic        BERRn;
    logic        DBENn;
    logic        RAM_CSn;
    logic        IO_CSn;
    logic [1:0]  SIZE_L;
    modport master(output ADR_OUT, ASn, DSn, RWn, SIZE, IO_RDYn,
                   input DSACKn, BERRn, DBENn, RAM_CSn, IO_CSn, SIZE_L);
    modport slave(input ADR_OUT, ASn, DSn, RWn, SIZE, IO_RDYn,
                  output DSACKn, BERRn, DBENn, RAM_CSn, IO_CSn, SIZE_L);
endinterface

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68030 bus cycle controller -- region decode, wait states, DSACKn/BERRn generation.
// Define BUS_CTRL_TIMEOUT_EN to enable the bus-error watchdog.
module m68k_bus_ctrl #(
    parameter logic [31:0] RAM_BASE = 32'h0000_0000,
    parameter logic [31:0] RAM_MASK = 32'hFFFF_0000,
    parameter int unsigned RAM_WAIT = 1,
    parameter logic [31:0] IO_BASE  = 32'hFFFF_0000,
    parameter logic [31:0] IO_MASK  = 32'hFFFF_FF00,
    parameter int unsigned IO_WAIT  = 3,
    parameter logic [1:0]  IO_WIDTH = 2'b10,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic            clk,
    input logic            RESETn,
    m68k_bus_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_BERR} state_t;
    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic        rw_q, rw_d, io_q, io_d, as_q;
    logic [1:0]  size_q, size_d, dsack_q, dsack_d;
    logic [3:0]  wcnt_q, wcnt_d, reg_wait;
    logic        berr_q, berr_d, dben_q, dben_d, ramcs_q, ramcs_d, iocs_q, iocs_d;
    logic        hit_ram, hit_io, sel_io, wzero, ack_ok, tmo, active;
`ifdef BUS_CTRL_TIMEOUT_EN
    logic [7:0] tcnt_q;
    always_ff @(posedge clk or negedge RESETn)
        if (!RESETn) tcnt_q <= '0;
        else tcnt_q <= (state_q == S_DECODE || state_q == S_WAIT) ? tcnt_q + 8'd1 : 8'd0;
    assign tmo = tcnt_q == 8'(TIMEOUT - 1);
`else
    // Watchdog removed; TIMEOUT stays so instantiations are portable between builds.
    assign tmo = TIMEOUT == 0;
`endif
    always_comb begin
        hit_ram  = (adr_q & RAM_MASK) == RAM_BASE;
        hit_io   = !hit_ram && (adr_q & IO_MASK) == IO_BASE;
        sel_io   = state_q == S_DECODE ? hit_io : io_q;
        reg_wait = hit_io ? 4'(IO_WAIT) : 4'(RAM_WAIT);
        // The decode cycle itself counts as the first wait cycle.
        wzero    = state_q == S_DECODE ? reg_wait == 4'd0 : wcnt_q == 4'd0;
        ack_ok   = wzero && (!sel_io || !bus.IO_RDYn) && (rw_q || !bus.DSn);
    end
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        io_d    = io_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: if (!bus.ASn && as_q) begin
                state_d = S_DECODE;
                adr_d   = bus.ADR_OUT;
                rw_d    = bus.RWn;
                size_d  = bus.SIZE;
            end
            S_DECODE: begin
                io_d   = hit_io;
                wcnt_d = reg_wait == 4'd0 ? 4'd0 : reg_wait - 4'd1;
                if (bus.ASn) state_d = S_IDLE;
                else if (!hit_ram && !hit_io) state_d = S_BERR;
                else if (ack_ok) state_d = S_ACK;
                else if (tmo) state_d = S_BERR;
                else state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d  = wcnt_q == 4'd0 ? 4'd0 : wcnt_q - 4'd1;
                state_d = bus.ASn ? S_IDLE : ack_ok ? S_ACK : tmo ? S_BERR : S_WAIT;
            end
            S_ACK, S_BERR: if (bus.ASn) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered copies of what the next state implies.
        active  = state_d == S_WAIT || state_d == S_ACK;
        dsack_d = state_d == S_ACK ? (io_d ? IO_WIDTH : 2'b00) : 2'b11;
        berr_d  = state_d != S_BERR;
        dben_d  = !active;
        ramcs_d = !(active && !io_d);
        iocs_d  = !(active && io_d);
    end
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            rw_q    <= 1'b1;
            io_q    <= 1'b0;
            as_q    <= 1'b0;
            size_q  <= 2'b00;
            wcnt_q  <= '0;
            dsack_q <= 2'b11;
            berr_q  <= 1'b1;
            dben_q  <= 1'b1;
            ramcs_q <= 1'b1;
            iocs_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rw_q    <= rw_d;
            io_q    <= io_d;
            as_q    <= bus.ASn;
            size_q  <= size_d;
            wcnt_q  <= wcnt_d;
            dsack_q <= dsack_d;
            berr_q  <= berr_d;
            dben_q  <= dben_d;
            ramcs_q <= ramcs_d;
            iocs_q  <= iocs_d;
        end
    end
    assign bus.DSACKn  = dsack_q;
    assign bus.BERRn   = berr_q;
    assign bus.DBENn   = dben_q;
    assign bus.RAM_CSn = ramcs_q;
    assign bus.IO_CSn  = iocs_q;
    assign bus.SIZE_L  = size_q;
endmodule

// File: doc/m68k_bus_ctrl.md
# m68k_bus_ctrl

Bus cycle controller between the WF68K30 CPU bus and its slaves (block RAM bridge, I/O register file). It samples each asynchronous 68030 bus cycle and decodes the address into a RAM or I/O chip select. It inserts per-region wait states and returns DSACKn with the region's port width, or BERRn for unmapped or timed-out cycles. The block RAM bridge then sees a qualified DBENn/chip select instead of self-acknowledging every cycle.

## Interface
Parameters:
- RAM_BASE, 32'h0000_0000, RAM region base address.
- RAM_MASK, 32'hFFFF_0000, RAM region match mask; hit when (ADR_OUT & RAM_MASK) == RAM_BASE.
- RAM_WAIT, 1, wait cycles for RAM, range 0..15.
- IO_BASE, 32'hFFFF_0000, I/O region base address.
- IO_MASK, 32'hFFFF_FF00, I/O region match mask.
- IO_WAIT, 3, minimum wait cycles for I/O, range 0..15.
- IO_WIDTH, 2'b10, DSACKn code for I/O: 2'b00 = 32-bit, 2'b01 = 16-bit, 2'b10 = 8-bit. RAM is always 2'b00.
- TIMEOUT, 64, cycles from cycle start to bus error, range 2..255.

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- RESETn, in, 1, asynchronous active-low reset.
- ADR_OUT, in, 32, CPU address.
- ASn, in, 1, address strobe, active low.
- DSn, in, 1, data strobe, active low.
- RWn, in, 1, 1 = read, 0 = write.
- SIZE, in, 2, transfer size; latched and passed through.
- IO_RDYn, in, 1, I/O slave ready, active low.
- DSACKn, out, 2, {DSACK1n, DSACK0n} to the CPU.
- BERRn, out, 1, bus error, active low.
- DBENn, out, 1, data buffer enable to the slaves, active low.
- RAM_CSn, out, 1, RAM select, active low.
- IO_CSn, out, 1, I/O select, active low.
- SIZE_L, out, 2, SIZE latched at decode.

## Operation
- All outputs are registered. Reset values: DSACKn = 2'b11, BERRn = 1, DBENn = 1, RAM_CSn = 1, IO_CSn = 1, SIZE_L = 2'b00. State resets to IDLE.
- State IDLE: all strobes negated. When ASn is sampled low, latch RWn and SIZE and go to DECODE.
- State DECODE: evaluate the region compare on the latched address. RAM takes priority if both regions match.
  - Hit: assert the selected CSn and DBENn, load wcnt = region wait, go to WAIT.
  - No hit: go to BERR.
- State WAIT: the acknowledge condition is wcnt == 0, plus IO_RDYn low for I/O cycles, plus DSn low for write cycles.
  - Condition true: go to ACK and drive DSACKn = 2'b00 for RAM or IO_WIDTH for I/O.
  - Condition false: decrement wcnt, saturating at 0.
- State ACK: hold DSACKn, CSn and DBENn until ASn is sampled high, then go to IDLE with all outputs negated on that edge.
- State BERR: BERRn low, CSn and DBENn negated. Go to IDLE when ASn is sampled high.
- Abort: ASn sampled high in DECODE or WAIT returns to IDLE on that edge with all outputs negated and no ack.
- Timeout counter tcnt (8 bit) clears in IDLE and increments every cycle in DECODE and WAIT. When tcnt reaches TIMEOUT-1 without the ack condition, go to BERR.
- Ack and timeout on the same edge: ACK wins.
- Back-to-back cycles: ASn must be seen high for at least one edge before a new cycle starts. ASn held low through ACK never starts a second cycle.

## Timing
- Let E0 be the first edge that samples ASn low.
- CSn and DBENn go low after E0+1.
- With a ready slave, DSACKn goes low after E0+1+W, where W = RAM_WAIT or IO_WAIT. RAM with the defaults acks after E0+2.
- Unmapped address: BERRn goes low after E0+1.
- Timeout: BERRn goes low after E0+TIMEOUT.
- Release: DSACKn, BERRn, CSn and DBENn all negate on the first edge that samples ASn high.
- Reset asserted mid-cycle: outputs return to reset values immediately. After RESETn deasserts, the block stays in IDLE until a fresh ASn falling edge.

## Configuration
- BUS_CTRL_TIMEOUT_EN defined: the timeout watchdog is active as described above.
- BUS_CTRL_TIMEOUT_EN undefined: tcnt is removed and a WAIT state holds indefinitely until ack or abort. BERRn asserts only for unmapped addresses.

## Test plan
- RAM read, defaults: ADR_OUT = 0x0000_0100, RWn = 1, ASn low at E0 -> RAM_CSn low after E0+1, DSACKn = 00 after E0+2; ASn high -> all negated on the next edge.
- I/O write: ADR_OUT = 0xFFFF_0004, RWn = 0, DSn low at E0+2, IO_RDYn low at E0+5 -> DSACKn = 10 after E0+6, not earlier.
- Unmapped read: ADR_OUT = 0x8000_0000 -> BERRn low after E0+1, DSACKn stays 11, CSn never asserted.
- Timeout (macro defined): I/O read with IO_RDYn held high -> BERRn low after E0+64. Macro undefined -> no BERRn within 200 cycles; IO_RDYn low then acks.
- Abort and reset: ASn negated in WAIT -> IDLE next edge, no DSACKn. RESETn pulsed low during ACK -> DSACKn = 11 immediately; a following RAM read acks normally.
- SIZE passthrough: SIZE = 2'b11 at E0 -> SIZE_L = 2'b11 from E0+1 until the next decode.
